cell_rule_engine: RTL and testbench
===================================

// Module: cell_rule_engine
// PURPOSE
//  Per-cell next-state engine. Consumes the registered 4-bit neighbour count from the
//  neighbour adder, applies a birth/survive rule on a global step handshake, and holds
//  the cell's alive bit. The alive bit fans back out as one adjSignals bit of each of
//  the eight neighbouring adders. One instance per grid cell.
// PARAMETERS
//  ADDER_LAT   2             cycles from a neighbour alive change to a valid neighbour_sum (>=1)
//  BIRTH_MASK  9'b000001000  bit n set: dead cell with n neighbours is born (default B3)
//  SURVIVE_MASK 9'b000001100 bit n set: live cell with n neighbours survives (default S23)
//  AGE_W       8             width of the age counter
//  INIT_STATE  1'b0          alive value after reset
// PORTS
//  clock          in   1      single clock; all logic on posedge
//  reset          in   1      synchronous, active-high
//  neighbour_sum  in   4      registered neighbour count from the adder, 0..8 legal
//  step           in   1      generation step request; single-cycle pulse, grid-wide
//  load_en        in   1      load an initial alive value
//  load_value     in   1      value written to alive when load_en is accepted
//  alive          out  1      current cell state
//  age            out  AGE_W  generations survived since last birth or load, saturating
//  busy           out  1      high while a step is in progress
//  done           out  1      one-cycle pulse: step committed, alive/age updated
//  changed        out  1      valid with done: 1 if alive toggled on this step
// BEHAVIOUR
//  Reset: state=IDLE, alive=INIT_STATE, age=0, busy=0, done=0, changed=0, settle count=0.
//  FSM:
//   IDLE   : step=1 -> SETTLE, cnt<=ADDER_LAT-1. Otherwise stay. busy=0.
//   SETTLE : busy=1; cnt!=0 -> cnt<=cnt-1; cnt==0 -> COMMIT.
//   COMMIT : busy=1; sample neighbour_sum; next=alive ? SURVIVE_MASK[sum] : BIRTH_MASK[sum];
//            alive<=next; done<=1; changed<=(next!=alive); -> IDLE.
//  Timing: step high in cycle 0 -> busy high cycles 1..ADDER_LAT+1 -> done=1 and new alive
//   visible in cycle ADDER_LAT+2. A step in the same cycle as done is accepted.
//  done and changed are one-cycle pulses; both 0 in every cycle without a commit.
//  Illegal sum 9..15: rule yields 0 (cell dies or stays dead).
//  Age: survive (1->1) -> age+1, saturating at all-ones; birth (0->1) or death -> age<=0;
//   dead stays dead -> age stays 0.
//  Load: load_en accepted in any state; alive<=load_value, age<=0, state<=IDLE, cnt<=0,
//   done=0, changed=0. An in-flight step is aborted with no done pulse. load_en and
//   step in the same IDLE cycle: load wins and step is dropped.
//  step while busy (SETTLE/COMMIT): ignored, no queueing.
//  Reset mid-step: overrides everything; next cycle matches the reset values above.
//  alive never changes during SETTLE, so neighbour sums settle across the whole grid.
// TESTING
//  1. Reset, INIT_STATE=0 -> alive=0, age=0, busy=0, done=0 in first post-reset cycle.
//  2. Load 0, sum=3, step in cycle 0 (ADDER_LAT=2) -> busy cycles 1-3, cycle 4: done=1,
//     alive=1, changed=1, age=0.
//  3. Load 1, sum=2, three steps -> alive stays 1, age 1,2,3, changed=0; AGE_W=2 with
//     five steps -> age saturates at 3.
//  4. alive=1, sum=4 step -> alive=0, age=0, changed=1; sum=12 on a dead cell -> stays 0.
//  5. step in cycle 0, second step in cycle 2, load_en=1 in cycle 3 with load_value=1
//     -> second step ignored, no done, alive=1, busy=0 in cycle 4.
//  6. step then reset in cycle 2 -> cycle 3 matches reset values, no done pulse.

Source files
------------

// File: rtl/cell_rule_engine.sv
// cell_rule_engine: per-cell next-state engine for a cellular-automaton grid.
// Waits for the neighbour adder to settle after a grid-wide step request, then applies a
// birth/survive rule to the registered neighbour count and commits the new alive bit.
//
// Ports
//   clk_i            single clock, all logic on posedge
//   rst_i            synchronous, active-high reset
//   neighbour_sum_i  registered neighbour count from the adder (0..8 legal)
//   step_i           single-cycle grid-wide generation step request
//   load_en_i        load an initial alive value (accepted in any state)
//   load_value_i     value written to alive on load
//   alive_o          current cell state
//   age_o            generations survived since last birth or load, saturating
//   busy_o           high while a step is in progress
//   done_o           one-cycle pulse: step committed, alive/age updated
//   changed_o        valid with done_o: alive toggled on this step
module cell_rule_engine #(
  parameter int unsigned ADDER_LAT    = 2,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
  parameter int unsigned AGE_W        = 8,
  parameter logic        INIT_STATE   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       neighbour_sum_i,
  input  logic             step_i,
  input  logic             load_en_i,
  input  logic             load_value_i,
  output logic             alive_o,
  output logic [AGE_W-1:0] age_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             changed_o
);

  localparam int unsigned CntW = $clog2(ADDER_LAT + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCommit} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              alive_q, alive_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              done_q, done_d;
  logic              changed_q, changed_d;
  logic              rule_bit;

  // Counts 9..15 are illegal and always yield a dead cell.
  always_comb begin
    rule_bit = 1'b0;
    if (neighbour_sum_i <= 4'd8) begin
      rule_bit = alive_q ? SURVIVE_MASK[neighbour_sum_i] : BIRTH_MASK[neighbour_sum_i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alive_d   = alive_q;
    age_d     = age_q;
    done_d    = 1'b0;
    changed_d = 1'b0;
    if (load_en_i) begin
      // Load aborts any in-flight step and wins over a simultaneous step request.
      state_d = StIdle;
      cnt_d   = '0;
      alive_d = load_value_i;
      age_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (step_i) begin
            state_d = StSettle;
            cnt_d   = CntW'(ADDER_LAT - 1);
          end
        end
        StSettle: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            state_d = StCommit;
          end
        end
        StCommit: begin
          alive_d   = rule_bit;
          done_d    = 1'b1;
          changed_d = rule_bit ^ alive_q;
          if (alive_q && rule_bit) begin
            age_d = (age_q == '1) ? age_q : age_q + AGE_W'(1);
          end else begin
            age_d = '0;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      alive_q   <= INIT_STATE;
      age_q     <= '0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alive_q   <= alive_d;
      age_q     <= age_d;
      done_q    <= done_d;
      changed_q <= changed_d;
    end
  end

  assign alive_o   = alive_q;
  assign age_o     = age_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_cell_rule_engine.sv
// Self-checking bench for cell_rule_engine: directed scenarios plus a randomized run,
// compared against a rule-level model. Two instances share stimulus; one has a 2-bit age
// so saturation is reachable quickly.
module tb_cell_rule_engine;

  localparam int unsigned AdderLat = 2;

  logic       clk;
  logic       rst;
  logic [3:0] neighbour_sum;
  logic       step;
  logic       load_en;
  logic       load_value;

  logic       alive_a, busy_a, done_a, changed_a;
  logic [7:0] age_a;
  logic       alive_b, busy_b, done_b, changed_b;
  logic [1:0] age_b;

  cell_rule_engine #(
    .ADDER_LAT(AdderLat), .BIRTH_MASK(9'b000001000), .SURVIVE_MASK(9'b000001100),
    .AGE_W(8), .INIT_STATE(1'b0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .neighbour_sum_i(neighbour_sum), .step_i(step),
    .load_en_i(load_en), .load_value_i(load_value), .alive_o(alive_a), .age_o(age_a),
    .busy_o(busy_a), .done_o(done_a), .changed_o(changed_a)
  );

  cell_rule_engine #(
    .ADDER_LAT(AdderLat), .BIRTH_MASK(9'b000001000), .SURVIVE_MASK(9'b000001100),
    .AGE_W(2), .INIT_STATE(1'b0)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .neighbour_sum_i(neighbour_sum), .step_i(step),
    .load_en_i(load_en), .load_value_i(load_value), .alive_o(alive_b), .age_o(age_b),
    .busy_o(busy_b), .done_o(done_b), .changed_o(changed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: alive bit and plain integer ages.
  bit m_alive;
  int m_age8;
  int m_age2;
  bit m_changed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // B3/S23 written as plain rules.
  function automatic bit rule(input bit alive, input int sum);
    if (alive) return (sum == 2) || (sum == 3);
    return sum == 3;
  endfunction

  function automatic int sat_inc(input int a, input int maxv);
    return (a >= maxv) ? maxv : a + 1;
  endfunction

  task automatic model_commit(input int sum);
    bit nxt;
    nxt = rule(m_alive, sum);
    m_changed = (nxt != m_alive);
    if (m_alive && nxt) begin
      m_age8 = sat_inc(m_age8, 255);
      m_age2 = sat_inc(m_age2, 3);
    end else begin
      m_age8 = 0;
      m_age2 = 0;
    end
    m_alive = nxt;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, ".alive"}, alive_a, m_alive);
    chk({tag, ".age"}, age_a, m_age8);
    chk({tag, ".age2"}, age_b, m_age2);
    chk({tag, ".busy"}, busy_a, 0);
    chk({tag, ".done"}, done_a, 0);
  endtask

  task automatic do_load(input bit v);
    load_en = 1'b1;
    load_value = v;
    tick();
    load_en = 1'b0;
    m_alive = v;
    m_age8 = 0;
    m_age2 = 0;
    check_idle_state("load");
    chk("load.changed", changed_a, 0);
  endtask

  // Step issued in current cycle (0); sum may wander during settle and is only meaningful
  // in the commit cycle. Spurious steps while busy must be ignored.
  task automatic do_step(input int sum, input bit noisy);
    bit old_alive;
    old_alive = m_alive;
    step = 1'b1;
    neighbour_sum = noisy ? 4'($urandom_range(0, 15)) : 4'(sum);
    tick();
    for (int c = 1; c <= int'(AdderLat) + 1; c++) begin
      step = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == int'(AdderLat) + 1) neighbour_sum = 4'(sum);
      else if (noisy) neighbour_sum = 4'($urandom_range(0, 15));
      chk("settle.busy", busy_a, 1);
      chk("settle.done", done_a, 0);
      chk("settle.alive", alive_a, old_alive);
      tick();
    end
    step = 1'b0;
    model_commit(sum);
    chk("commit.done", done_a, 1);
    chk("commit.busy", busy_a, 0);
    chk("commit.alive", alive_a, m_alive);
    chk("commit.changed", changed_a, m_changed);
    chk("commit.age", age_a, m_age8);
    chk("commit.age2", age_b, m_age2);
    chk("commit.done2", done_b, 1);
  endtask

  initial begin
    rst = 1'b1;
    neighbour_sum = 4'd0;
    step = 1'b0;
    load_en = 1'b0;
    load_value = 1'b0;
    m_alive = 1'b0;
    m_age8 = 0;
    m_age2 = 0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_state("reset");
    chk("reset.changed", changed_a, 0);

    // Birth on exactly three neighbours.
    do_load(1'b0);
    do_step(3, 1'b0);

    // Survival on two; 2-bit age saturates after three survivals.
    do_load(1'b1);
    for (int i = 0; i < 5; i++) do_step(2, 1'b0);
    chk("sat.age8", age_a, 5);
    chk("sat.age2", age_b, 3);

    // Overcrowding death, then illegal count on a dead cell.
    do_step(4, 1'b0);
    do_step(12, 1'b0);
    tick();
    check_idle_state("idle_after");

    // Step in cycle 0, ignored step in cycle 2, load in cycle 3 aborts.
    neighbour_sum = 4'd3;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    load_en = 1'b1;
    load_value = 1'b1;
    tick();
    load_en = 1'b0;
    m_alive = 1'b1;
    m_age8 = 0;
    m_age2 = 0;
    check_idle_state("abort");
    tick();
    check_idle_state("abort_next");

    // Load and step together in IDLE: load wins, step dropped.
    load_en = 1'b1;
    load_value = 1'b0;
    step = 1'b1;
    tick();
    load_en = 1'b0;
    step = 1'b0;
    m_alive = 1'b0;
    check_idle_state("load_vs_step");

    // Reset mid-step after a live cell survives once.
    do_load(1'b1);
    do_step(2, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_alive = 1'b0;
    m_age8 = 0;
    m_age2 = 0;
    check_idle_state("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_state("post_reset");
    end

    // Randomized run: loads, noisy steps, and back-to-back steps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) do_load(1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0) do_step(int'($urandom_range(0, 15)), 1'b1);
      else do_step(int'($urandom_range(0, 4)), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check_idle_state("rand_idle");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
